// File: rtl/rmt_frame_filter.sv
// rmt_frame_filter: forwards matching RMT frames, drops the rest, decodes the recon header and counts pass/drop
module rmt_frame_filter #(
   parameter int DATA_WIDTH = 512,
   parameter int KEEP_WIDTH = DATA_WIDTH/8,
   parameter int HDR_BYTES  = 46
) (
   input  logic                  s_axis_clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic [15:0]           cfg_udp_port,
   input  logic                  s_axis_tvalid,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
   input  logic                  s_axis_tlast,
   output logic                  s_axis_tready,
   output logic                  m_axis_tvalid,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
   output logic                  m_axis_tlast,
   input  logic                  m_axis_tready,
   output logic                  hdr_valid,
   output logic [1:0]            hdr_func_type,
   output logic [7:0]            hdr_bitstream_id,
   output logic                  hdr_size_valid,
   output logic [31:0]           hdr_size,
   output logic [31:0]           stat_pass_count,
   output logic [31:0]           stat_drop_count
);
   localparam int HB = HDR_BYTES*8;
   typedef enum logic [1:0] {START, PASS, DROP} state_t;
   state_t r_state, w_next;
   logic                  r_m_tvalid, r_m_tlast, r_hdr_valid, r_size_valid;
   logic [DATA_WIDTH-1:0] r_m_tdata;
   logic [KEEP_WIDTH-1:0] r_m_tkeep;
   logic [1:0]            r_func_type;
   logic [7:0]            r_bitstream_id;
   logic [31:0]           r_size, r_pass, r_drop;
   logic                  w_out_free, w_beat, w_start, w_match, w_accept, w_reject, w_load;
   assign w_out_free    = !r_m_tvalid || m_axis_tready;
   assign s_axis_tready = (r_state == DROP) ? 1'b1 : w_out_free;
   assign w_beat        = s_axis_tvalid && s_axis_tready;
   assign w_start       = w_beat && (r_state == START);
   assign w_match       = enable && (&s_axis_tkeep[53:0])
                          && (s_axis_tdata[12*8+:8] == 8'h08) && (s_axis_tdata[13*8+:8] == 8'h00)
                          && (s_axis_tdata[23*8+:8] == 8'h11)
                          && ({s_axis_tdata[36*8+:8], s_axis_tdata[37*8+:8]} == cfg_udp_port);
   assign w_accept      = w_start && w_match;
   assign w_reject      = w_start && !w_match;
   assign w_load        = w_accept || (w_beat && (r_state == PASS));
   // frame state register
   always_ff @(posedge s_axis_clk) begin
      if (rst) r_state <= START;
      else     r_state <= w_next;
   end
   // tlast always ends the frame; a start beat picks PASS or DROP for the remainder
   always_comb begin
      w_next = r_state;
      if (w_beat && s_axis_tlast) w_next = START;
      else if (w_start)           w_next = w_match ? PASS : DROP;
   end
   // output register: load on forwarded beat, otherwise drain when downstream takes it
   always_ff @(posedge s_axis_clk) begin
      if (rst) begin
         r_m_tvalid <= 1'b0;
         r_m_tdata  <= '0;
         r_m_tkeep  <= '0;
         r_m_tlast  <= 1'b0;
      end else if (w_load) begin
         r_m_tvalid <= 1'b1;
         r_m_tdata  <= s_axis_tdata;
         r_m_tkeep  <= s_axis_tkeep;
         r_m_tlast  <= s_axis_tlast;
      end else if (m_axis_tready) begin
         r_m_tvalid <= 1'b0;
      end
   end
   // recon header sideband, latched on accept and pulsed alongside the first output beat
   always_ff @(posedge s_axis_clk) begin
      if (rst) begin
         r_hdr_valid    <= 1'b0;
         r_func_type    <= '0;
         r_bitstream_id <= '0;
         r_size_valid   <= 1'b0;
         r_size         <= '0;
      end else begin
         r_hdr_valid <= w_accept;
         if (w_accept) begin
            r_func_type    <= s_axis_tdata[HB+:2];
            r_bitstream_id <= s_axis_tdata[HB+2+:8];
            r_size_valid   <= s_axis_tdata[HB+31];
            r_size         <= s_axis_tdata[HB+32+:32];
         end
      end
   end
   // saturating frame statistics
   always_ff @(posedge s_axis_clk) begin
      if (rst) begin
         r_pass <= '0;
         r_drop <= '0;
      end else begin
         if (w_accept && ~&r_pass) r_pass <= r_pass + 32'd1;
         if (w_reject && ~&r_drop) r_drop <= r_drop + 32'd1;
      end
   end
   assign m_axis_tvalid    = r_m_tvalid;
   assign m_axis_tdata     = r_m_tdata;
   assign m_axis_tkeep     = r_m_tkeep;
   assign m_axis_tlast     = r_m_tlast;
   assign hdr_valid        = r_hdr_valid;
   assign hdr_func_type    = r_func_type;
   assign hdr_bitstream_id = r_bitstream_id;
   assign hdr_size_valid   = r_size_valid;
   assign hdr_size         = r_size;
   assign stat_pass_count  = r_pass;
   assign stat_drop_count  = r_drop;
endmodule

// File: tb/tb_rmt_frame_filter.sv
// tb_rmt_frame_filter: directed table and sequence checks for rmt_frame_filter
module tb_rmt_frame_filter;
   logic         s_axis_clk = 1'b0;
   logic         rst = 1'b1;
   logic         enable = 1'b1;
   logic [15:0]  cfg_udp_port = 16'h1234;
   logic         s_axis_tvalid = 1'b0;
   logic [511:0] s_axis_tdata = '0;
   logic [63:0]  s_axis_tkeep = '0;
   logic         s_axis_tlast = 1'b0;
   logic         s_axis_tready;
   logic         m_axis_tvalid;
   logic [511:0] m_axis_tdata;
   logic [63:0]  m_axis_tkeep;
   logic         m_axis_tlast;
   logic         m_axis_tready = 1'b1;
   logic         hdr_valid;
   logic [1:0]   hdr_func_type;
   logic [7:0]   hdr_bitstream_id;
   logic         hdr_size_valid;
   logic [31:0]  hdr_size;
   logic [31:0]  stat_pass_count;
   logic [31:0]  stat_drop_count;
   int           checks = 0;
   int           failures = 0;
   int           exp_pass = 0;
   int           exp_drop = 0;
   logic [63:0]  exp_recon = '0;
   localparam logic [63:0] ALL = 64'hFFFF_FFFF_FFFF_FFFF;
   rmt_frame_filter dut (
      .s_axis_clk(s_axis_clk), .rst(rst), .enable(enable), .cfg_udp_port(cfg_udp_port),
      .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
      .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
      .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
      .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
      .hdr_valid(hdr_valid), .hdr_func_type(hdr_func_type), .hdr_bitstream_id(hdr_bitstream_id),
      .hdr_size_valid(hdr_size_valid), .hdr_size(hdr_size),
      .stat_pass_count(stat_pass_count), .stat_drop_count(stat_drop_count)
   );
   always #5 s_axis_clk = ~s_axis_clk;
   typedef struct {
      logic        en;
      logic [15:0] eth;
      logic [7:0]  proto;
      logic [15:0] port;
      logic [63:0] keep;
      logic [63:0] recon;
      logic        exp_p;
   } vec_t;
   vec_t vecs [10];
   task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
      end
   endtask
   function automatic logic [511:0] mk(input logic [15:0] eth, input logic [7:0] pr,
                                       input logic [15:0] port, input logic [63:0] recon,
                                       input logic [7:0] seed);
      logic [511:0] d;
      for (int i = 0; i < 64; i++) d[i*8+:8] = 8'(i) ^ seed;
      d[12*8+:8] = eth[15:8];
      d[13*8+:8] = eth[7:0];
      d[23*8+:8] = pr;
      d[36*8+:8] = port[15:8];
      d[37*8+:8] = port[7:0];
      d[46*8+:64] = recon;
      return d;
   endfunction
   task automatic hdr_chk(input string nm);
      chk({nm, "_hdr"}, {hdr_size, hdr_size_valid, hdr_bitstream_id, hdr_func_type},
          {exp_recon[63:32], exp_recon[31], exp_recon[9:2], exp_recon[1:0]});
   endtask
   task automatic cnt_chk(input string nm);
      chk({nm, "_pass"}, stat_pass_count, 32'(exp_pass));
      chk({nm, "_drop"}, stat_drop_count, 32'(exp_drop));
   endtask
   // single-beat frame; called at a negedge with the output idle
   task automatic frame1(input logic [511:0] d, input logic [63:0] k, input logic exp_p, input string nm);
      s_axis_tvalid = 1'b1; s_axis_tdata = d; s_axis_tkeep = k; s_axis_tlast = 1'b1; m_axis_tready = 1'b1;
      #1 chk({nm, "_srdy"}, s_axis_tready, 1'b1);
      @(negedge s_axis_clk);
      s_axis_tvalid = 1'b0;
      if (exp_p) begin exp_pass++; exp_recon = d[46*8+:64]; end
      else exp_drop++;
      #1;
      chk({nm, "_mvalid"}, m_axis_tvalid, exp_p);
      chk({nm, "_hvalid"}, hdr_valid, exp_p);
      if (exp_p) begin
         chk({nm, "_data"}, m_axis_tdata, d);
         chk({nm, "_keep"}, m_axis_tkeep, k);
         chk({nm, "_last"}, m_axis_tlast, 1'b1);
      end
      cnt_chk(nm);
      hdr_chk(nm);
      @(negedge s_axis_clk);
      #1;
      chk({nm, "_drain"}, {m_axis_tvalid, hdr_valid}, 2'b00);
   endtask
   initial begin
      #200000;
      $display("FAIL timeout act=running exp=finished");
      $fatal(1, "timeout");
   end
   initial begin
      logic [511:0] q [3];
      int i, o, hv;
      vecs[0] = '{1'b1, 16'h0800, 8'h11, 16'h1234, ALL, 64'h0000_0400_8000_0028, 1'b1};
      vecs[1] = '{1'b0, 16'h0800, 8'h11, 16'h1234, ALL, 64'h0000_0999_8000_0005, 1'b0};
      vecs[2] = '{1'b1, 16'h0806, 8'h11, 16'h1234, ALL, 64'h0000_0001_0000_0001, 1'b0};
      vecs[3] = '{1'b1, 16'h0008, 8'h11, 16'h1234, ALL, 64'h0000_0002_0000_0002, 1'b0};
      vecs[4] = '{1'b1, 16'h0800, 8'h06, 16'h1234, ALL, 64'h0000_0003_0000_0003, 1'b0};
      vecs[5] = '{1'b1, 16'h0800, 8'h11, 16'h1235, ALL, 64'h0000_0004_0000_0004, 1'b0};
      vecs[6] = '{1'b1, 16'h0800, 8'h11, 16'h3412, ALL, 64'h0000_0005_0000_0005, 1'b0};
      vecs[7] = '{1'b1, 16'h0800, 8'h11, 16'h1234, {10'h3FF, 54'h1F_FFFF_FFFF_FFFF}, 64'h0000_0006_0000_0006, 1'b0};
      vecs[8] = '{1'b1, 16'h0800, 8'h11, 16'h1234, 64'h003F_FFFF_FFFF_FFFF, 64'h1234_5678_0000_03FF, 1'b1};
      vecs[9] = '{1'b1, 16'h0800, 8'h11, 16'h1234, ALL, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
      // reset state
      @(negedge s_axis_clk);
      @(negedge s_axis_clk);
      #1;
      chk("rst_m", {m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast}, '0);
      chk("rst_h", {hdr_valid, hdr_func_type, hdr_bitstream_id, hdr_size_valid, hdr_size}, '0);
      cnt_chk("rst");
      rst = 1'b0;
      @(negedge s_axis_clk);
      // table of single-beat start variations
      for (int n = 0; n < 10; n++) begin
         enable = vecs[n].en;
         cfg_udp_port = 16'h1234;
         frame1(mk(vecs[n].eth, vecs[n].proto, vecs[n].port, vecs[n].recon, 8'(n * 17)),
                vecs[n].keep, vecs[n].exp_p, $sformatf("v%0d", n));
         if (n == 0) chk("tp1_fields", {hdr_size, hdr_size_valid, hdr_bitstream_id, hdr_func_type},
                         {32'h400, 1'b1, 8'h0A, 2'd0});
      end
      enable = 1'b1;
      // 4-beat drop with downstream stalled, then a passing frame
      m_axis_tready = 1'b0;
      for (int b = 0; b < 4; b++) begin
         s_axis_tvalid = 1'b1;
         s_axis_tdata = mk(16'h0800, 8'h11, (b == 0) ? 16'h1235 : 16'h1234, 64'h77, 8'(b + 40));
         s_axis_tkeep = ALL; s_axis_tlast = (b == 3);
         #1 chk($sformatf("drop4_srdy%0d", b), s_axis_tready, 1'b1);
         @(negedge s_axis_clk);
         #1 chk($sformatf("drop4_mvalid%0d", b), m_axis_tvalid, 1'b0);
      end
      s_axis_tvalid = 1'b0;
      exp_drop++;
      cnt_chk("drop4");
      frame1(mk(16'h0800, 8'h11, 16'h1234, 64'h0000_0010_0000_0100, 8'h5A), ALL, 1'b1, "after_drop4");
      // 3-beat frame under toggling backpressure, cfg changed mid-frame
      q[0] = mk(16'h0800, 8'h11, 16'h1234, 64'hCAFE_0001_8000_0042, 8'hA5);
      q[1] = {16{32'hDEAD_0001}};
      q[2] = {16{32'hBEEF_0002}};
      i = 0; o = 0; hv = 0;
      for (int c = 0; c < 40 && o < 3; c++) begin
         m_axis_tready = (c % 4 == 0) || (c % 4 == 3);
         s_axis_tvalid = (i < 3);
         if (i < 3) begin s_axis_tdata = q[i]; s_axis_tkeep = ALL; s_axis_tlast = (i == 2); end
         cfg_udp_port = (i > 0) ? 16'hBEEF : 16'h1234;
         #1;
         if (m_axis_tvalid && !m_axis_tready) chk("bp_srdy", s_axis_tready, 1'b0);
         hv += int'(hdr_valid);
         if (m_axis_tvalid && m_axis_tready) begin
            chk($sformatf("bp_data%0d", o), m_axis_tdata, q[o]);
            chk($sformatf("bp_last%0d", o), m_axis_tlast, (o == 2));
            o++;
         end
         if (s_axis_tvalid && s_axis_tready) i++;
         @(negedge s_axis_clk);
      end
      s_axis_tvalid = 1'b0; m_axis_tready = 1'b1; cfg_udp_port = 16'h1234;
      exp_pass++; exp_recon = q[0][46*8+:64];
      chk("bp_beats_out", 32'(o), 32'd3);
      chk("bp_hvalid_pulses", 32'(hv), 32'd1);
      #1 chk("bp_idle", m_axis_tvalid, 1'b0);
      cnt_chk("bp");
      hdr_chk("bp");
      @(negedge s_axis_clk);
      // enable low at start, raised on beat 2: whole frame drops
      for (int b = 0; b < 3; b++) begin
         enable = (b != 0);
         s_axis_tvalid = 1'b1;
         s_axis_tdata = mk(16'h0800, 8'h11, 16'h1234, 64'h99, 8'(b + 70));
         s_axis_tkeep = ALL; s_axis_tlast = (b == 2);
         @(negedge s_axis_clk);
         #1 chk($sformatf("en_mvalid%0d", b), m_axis_tvalid, 1'b0);
      end
      s_axis_tvalid = 1'b0;
      exp_drop++;
      cnt_chk("en");
      hdr_chk("en");
      frame1(mk(16'h0800, 8'h11, 16'h1234, 64'h0000_0020_0000_0200, 8'h33), ALL, 1'b1, "after_en");
      // reset on beat 2 of a 4-beat passing frame
      s_axis_tvalid = 1'b1; s_axis_tkeep = ALL; s_axis_tlast = 1'b0;
      s_axis_tdata = mk(16'h0800, 8'h11, 16'h1234, 64'h0000_0030_8000_0300, 8'h11);
      @(negedge s_axis_clk);
      #1 chk("rmid_beat0", m_axis_tvalid, 1'b1);
      s_axis_tdata = {16{32'h1111_2222}};
      rst = 1'b1;
      @(negedge s_axis_clk);
      rst = 1'b0; s_axis_tvalid = 1'b0;
      exp_pass = 0; exp_drop = 0; exp_recon = '0;
      #1;
      chk("rmid_m", {m_axis_tvalid, hdr_valid}, 2'b00);
      cnt_chk("rmid");
      hdr_chk("rmid");
      frame1(mk(16'h0800, 8'h11, 16'h1234, 64'h0000_0040_0000_0404, 8'h44), ALL, 1'b1, "after_rst");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
